// File: rtl/pipelined_rca_if.sv
// Operand/result stream bundle for pipelined_rca.
// Define PRCA_OVERFLOW_EN to add the signed-overflow result flag (ovf).
interface pipelined_rca_if #(
   parameter int N = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  a;
   logic [N-1:0]  b;
   logic          cin;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  sum;
   logic          cout;
`ifdef PRCA_OVERFLOW_EN
   logic          ovf;

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
`else
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout
   );

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout
   );
`endif
endinterface

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor with valid/ready streaming.
// The N-bit carry chain is cut into STAGES chunks of CHUNK bits; each stage
// ripples one chunk and registers it. Operand chunks not yet summed and result
// chunks already summed travel alongside in skew registers.
// Optional feature: define PRCA_OVERFLOW_EN to add a pipelined ovf output.
module pipelined_rca #(
   parameter int N      = 16,
   parameter int STAGES = 4
) (
   input  logic clk,
   input  logic rst,
   pipelined_rca_if.slave bus
);
   localparam int CHUNK = N / STAGES;

   logic          r_v   [STAGES];
   logic          r_c   [STAGES];
   logic [N-1:0]  r_a   [STAGES];
   logic [N-1:0]  r_b   [STAGES];
   logic [N-1:0]  r_sum [STAGES];

   logic          w_stall;
   logic          w_src_v   [STAGES];
   logic          w_src_c   [STAGES];
   logic [N-1:0]  w_src_a   [STAGES];
   logic [N-1:0]  w_src_b   [STAGES];
   logic [N-1:0]  w_src_sum [STAGES];
   logic [N-1:0]  w_nxt_sum [STAGES];
   logic [CHUNK:0] w_rip    [STAGES];

   // Bit-serial full-adder chain over one chunk; MSB of the result is carry-out.
   function automatic logic [CHUNK:0] f_ripple(
      input logic [CHUNK-1:0] x,
      input logic [CHUNK-1:0] y,
      input logic             ci
   );
      logic             c;
      logic [CHUNK:0]   res;
      c   = ci;
      res = '0;
      for (int i = 0; i < CHUNK; i++) begin
         res[i] = x[i] ^ y[i] ^ c;
         c      = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
      end
      res[CHUNK] = c;
      return res;
   endfunction

   // A held output freezes the whole pipe, bubbles included.
   assign w_stall       = r_v[STAGES-1] & ~bus.out_ready;
   assign bus.in_ready  = ~w_stall;
   assign bus.out_valid = r_v[STAGES-1];
   assign bus.sum       = r_sum[STAGES-1];
   assign bus.cout      = r_c[STAGES-1];

   // Stage inputs: stage 0 takes the bus (with subtract folded in), later stages the previous register.
   always_comb begin
      w_src_v[0]   = bus.in_valid;
      w_src_a[0]   = bus.a;
      w_src_b[0]   = bus.sub ? ~bus.b : bus.b;
      w_src_c[0]   = bus.sub | bus.cin;
      w_src_sum[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         w_src_v[k]   = r_v[k-1];
         w_src_a[k]   = r_a[k-1];
         w_src_b[k]   = r_b[k-1];
         w_src_c[k]   = r_c[k-1];
         w_src_sum[k] = r_sum[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         w_rip[k]     = f_ripple(w_src_a[k][k*CHUNK +: CHUNK],
                                 w_src_b[k][k*CHUNK +: CHUNK],
                                 w_src_c[k]);
         w_nxt_sum[k] = w_src_sum[k];
         w_nxt_sum[k][k*CHUNK +: CHUNK] = w_rip[k][CHUNK-1:0];
      end
   end

   // Stage registers advance together unless the output is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_v[k]   <= 1'b0;
            r_c[k]   <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
         end
      end else if (!w_stall) begin
         for (int k = 0; k < STAGES; k++) begin
            r_v[k]   <= w_src_v[k];
            r_c[k]   <= w_rip[k][CHUNK];
            r_a[k]   <= w_src_a[k];
            r_b[k]   <= w_src_b[k];
            r_sum[k] <= w_nxt_sum[k];
         end
      end
   end

`ifdef PRCA_OVERFLOW_EN
   logic r_ovf;
   logic w_ovf_nxt;

   // Carry into the MSB is recovered as s ^ a ^ b at that bit.
   assign w_ovf_nxt = w_rip[STAGES-1][CHUNK]
                    ^ (w_nxt_sum[STAGES-1][N-1] ^ w_src_a[STAGES-1][N-1] ^ w_src_b[STAGES-1][N-1]);
   assign bus.ovf   = r_ovf;

   // Overflow flag rides with the final stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (!w_stall) begin
         r_ovf <= w_ovf_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed bench for pipelined_rca (N=16, STAGES=4).
module tb_pipelined_rca;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   pipelined_rca_if #(.N(16)) bus ();

   pipelined_rca #(.N(16), .STAGES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stream vectors: a, b, cin, sub -> sum, cout (hand-computed)
   logic [15:0] tab_a   [8] = '{16'h0001, 16'h1234, 16'hFFFF, 16'h8000, 16'h0010, 16'h0000, 16'hABCD, 16'hF000};
   logic [15:0] tab_b   [8] = '{16'h0002, 16'h1111, 16'h0001, 16'h8000, 16'h0001, 16'h0001, 16'h1111, 16'h1000};
   logic        tab_ci  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic        tab_sb  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [15:0] tab_s   [8] = '{16'h0003, 16'h2346, 16'h0000, 16'h0000, 16'h000F, 16'hFFFF, 16'hBCDE, 16'h0001};
   logic        tab_co  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
      bus.a   = a;
      bus.b   = b;
      bus.cin = ci;
      bus.sub = sb;
   endtask

   // One isolated beat: out_valid must rise exactly 4 cycles after acceptance.
   task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb,
                          input logic [15:0] es, input logic ec, input logic eo);
      drive(a, b, ci, sb);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
         tick();
      end
      chk({tag, "_vld"},  32'(bus.out_valid), 32'd1);
      chk({tag, "_sum"},  32'(bus.sum), 32'(es));
      chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
`ifdef PRCA_OVERFLOW_EN
      chk({tag, "_ovf"},  32'(bus.ovf), 32'(eo));
`endif
      tick();
      chk({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      int in_idx;
      int out_idx;
      int stall_left;
      bit stalled_once;

      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drive(16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_vld",   32'(bus.out_valid), 32'd0);
      chk("rst_sum",   32'(bus.sum), 32'd0);
      chk("rst_cout",  32'(bus.cout), 32'd0);
      chk("rst_rdy",   32'(bus.in_ready), 32'd1);
`ifdef PRCA_OVERFLOW_EN
      chk("rst_ovf",   32'(bus.ovf), 32'd0);
`endif
      tick();

      // Isolated beats: chunk-crossing carry, full ripple, subtract, overflow corners.
      run_one("ff_p1",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_one("ffff_c",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_one("5m7",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_one("7m5",     16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
      run_one("max_p1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_one("min_m1",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_one("1p1",     16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
      run_one("sub_cin", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

      // Back-to-back stream, consumer always ready.
      bus.out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c < 8) begin
            drive(tab_a[c], tab_b[c], tab_ci[c], tab_sb[c]);
            bus.in_valid = 1'b1;
            #1;
            chk("strm_rdy", 32'(bus.in_ready), 32'd1);
         end else begin
            bus.in_valid = 1'b0;
         end
         tick();
         chk("strm_vld", 32'(bus.out_valid), (c >= 3 && c <= 10) ? 32'd1 : 32'd0);
         if (c >= 3 && c <= 10) begin
            chk("strm_sum",  32'(bus.sum),  32'(tab_s[c-3]));
            chk("strm_cout", 32'(bus.cout), 32'(tab_co[c-3]));
         end
      end

      // Stream with a 3-cycle consumer stall once the first result appears.
      in_idx = 0;
      out_idx = 0;
      stall_left = 0;
      stalled_once = 1'b0;
      for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
         bus.in_valid = (in_idx < 8);
         if (in_idx < 8) drive(tab_a[in_idx], tab_b[in_idx], tab_ci[in_idx], tab_sb[in_idx]);
         if (bus.out_valid && !stalled_once) begin
            stalled_once = 1'b1;
            stall_left = 3;
         end
         bus.out_ready = (stall_left == 0);
         #1;
         if (stall_left > 0) begin
            chk("stl_rdy",  32'(bus.in_ready), 32'd0);
            chk("stl_vld",  32'(bus.out_valid), 32'd1);
            chk("stl_sum",  32'(bus.sum),  32'(tab_s[out_idx]));
            chk("stl_cout", 32'(bus.cout), 32'(tab_co[out_idx]));
            stall_left--;
         end else if (bus.out_valid) begin
            chk("rel_sum",  32'(bus.sum),  32'(tab_s[out_idx]));
            chk("rel_cout", 32'(bus.cout), 32'(tab_co[out_idx]));
            out_idx++;
         end
         if (bus.in_valid && bus.in_ready) in_idx++;
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("stl_count", 32'(out_idx), 32'd8);
      chk("stl_once",  32'(stalled_once), 32'd1);
      chk("stl_nodup", 32'(bus.out_valid), 32'd0);
      tick();

      // Reset with three beats in flight.
      for (int i = 0; i < 3; i++) begin
         drive(tab_a[i], tab_b[i], tab_ci[i], tab_sb[i]);
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_vld",  32'(bus.out_valid), 32'd0);
      chk("mrst_sum",  32'(bus.sum), 32'd0);
      chk("mrst_cout", 32'(bus.cout), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mrst_quiet", 32'(bus.out_valid), 32'd0);
      end
      run_one("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
